// File: rtl/ttest_hls_deadlock_reporter_if.sv
// Report channel of the HLS deadlock reporter: a valid/ready handshake carrying
// the captured per-process idle/block snapshot and its capture timestamp.
// The reporter drives the master side; the report consumer uses the slave side.
interface ttest_hls_deadlock_reporter_if #(
  parameter int NUM_PROC = 12,
  parameter int TS_WIDTH = 32
);

  logic                rpt_valid;
  logic                rpt_ready;
  logic [NUM_PROC-1:0] rpt_idle;
  logic [NUM_PROC-1:0] rpt_block;
  logic [TS_WIDTH-1:0] rpt_timestamp;

  modport master (
    output rpt_valid,
    output rpt_idle,
    output rpt_block,
    output rpt_timestamp,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_idle,
    input  rpt_block,
    input  rpt_timestamp,
    output rpt_ready
  );

endinterface

// File: rtl/ttest_hls_deadlock_reporter.sv
// HLS dataflow deadlock reporter.
// Filters the monitor's registered `block` indication with a persistence
// counter; once `block` has stayed high (with `enable` set) for PERSIST_CYCLES
// consecutive edges it captures the per-process idle/block vectors and offers
// them on the report channel until the consumer accepts. A HOLD state then
// suppresses re-reporting of the same episode until `block` drops.
// A sticky flag and a saturating episode counter feed the status path.
//
// Optional feature macro: TTEST_DEADLOCK_TIMESTAMP_EN
//   defined   -> free-running TS_WIDTH-bit cycle counter, latched on capture
//   undefined -> no counter, rpt_timestamp tied to zero
module ttest_hls_deadlock_reporter #(
  parameter int NUM_PROC       = 12,
  parameter int PERSIST_CYCLES = 16,
  parameter int TS_WIDTH       = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  block,
  input  logic [NUM_PROC-1:0]   proc_idle_vec,
  input  logic [NUM_PROC-1:0]   proc_block_vec,
  input  logic                  clear,
  output logic                  deadlock_flag,
  output logic [7:0]            episode_cnt,
  ttest_hls_deadlock_reporter_if.master rpt
);

  // Persistence counter is wide enough for the full 1..65535 range.
  localparam int CW = 16;
  // Counter value seen at the edge that completes the persistence window.
  localparam logic [CW-1:0] LAST_CNT = CW'(PERSIST_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_REPORT,
    ST_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          capture;
  logic          armed;

  assign armed = enable & block;

  // Next-state logic: persistence filter, report wait and re-arm hold.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (armed) begin
          if (PERSIST_CYCLES == 1) begin
            capture = 1'b1;
            state_d = ST_REPORT;
          end else begin
            cnt_d   = CW'(1);
            state_d = ST_COUNT;
          end
        end
      end
      ST_COUNT: begin
        if (!armed) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == LAST_CNT) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = ST_REPORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // Enable is deliberately ignored here: a pending report always completes.
      ST_REPORT: begin
        if (rpt.rpt_ready) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!armed) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and persistence counter registers.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Report channel: valid mirrors the next state, snapshot loads only on capture.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rpt.rpt_valid <= 1'b0;
      rpt.rpt_idle  <= '0;
      rpt.rpt_block <= '0;
    end else begin
      rpt.rpt_valid <= (state_d == ST_REPORT);
      if (capture) begin
        rpt.rpt_idle  <= proc_idle_vec;
        rpt.rpt_block <= proc_block_vec;
      end
    end
  end

  // Status path: sticky flag and saturating episode count; capture beats clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      deadlock_flag <= 1'b0;
      episode_cnt   <= '0;
    end else if (capture) begin
      deadlock_flag <= 1'b1;
      if (clear) begin
        episode_cnt <= 8'd1;
      end else if (episode_cnt != 8'hFF) begin
        episode_cnt <= episode_cnt + 8'd1;
      end
    end else if (clear) begin
      deadlock_flag <= 1'b0;
      episode_cnt   <= '0;
    end
  end

`ifdef TTEST_DEADLOCK_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;

  // Free-running cycle counter, wrapping modulo 2^TS_WIDTH.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_WIDTH'(1);
    end
  end

  // Latch the counter value present at the capture edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rpt.rpt_timestamp <= '0;
    end else if (capture) begin
      rpt.rpt_timestamp <= ts_q;
    end
  end
`else
  assign rpt.rpt_timestamp = '0;
`endif

endmodule
